// File: rtl/heart_led_pwm.sv
// Heartbeat LED driver: maps the heartbeat phase to a "lub-dub" brightness envelope,
// slews the brightness once per PWM period and drives an active-low LED.
module heart_led_pwm #(
    parameter int PWM_DIV = 4,
    parameter int SLEW    = 16
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       en_in,
    input  logic [3:0] heart_cnt_in,
    output logic       led_n_out,
    output logic       beat_out,
    output logic [7:0] level_out,
    output logic       err_out
);

    localparam logic [7:0] DIV_LAST = 8'(PWM_DIV - 1);
    localparam logic [8:0] SLEW_9   = 9'(SLEW);

    // Phases 4..15 are dark; out-of-range phases fall through to the dark default.
    function automatic logic [7:0] phase_target(input logic [3:0] phase);
        logic [7:0] t;
        case (phase)
            4'd0:    t = 8'd255;
            4'd1:    t = 8'd96;
            4'd2:    t = 8'd192;
            4'd3:    t = 8'd32;
            default: t = 8'd0;
        endcase
        return t;
    endfunction

    logic [3:0] cnt_q;
    logic [3:0] cnt_prev;
    logic [7:0] target;
    logic [7:0] presc;
    logic [7:0] pwm_cnt;
    logic [7:0] level;
    logic       tick;
    logic       period_end;
    logic [8:0] level_up;
    logic [8:0] level_dn;
    logic [7:0] level_next;

    // Period timing and the clamped slew step, all in 9 bits so nothing wraps.
    always_comb begin
        tick       = (presc == DIV_LAST);
        period_end = tick && (pwm_cnt == 8'd255);
        level_up   = {1'b0, level} + SLEW_9;
        level_dn   = {1'b0, level} - SLEW_9;
        level_next = level;
        if (level < target) begin
            if (level_up > {1'b0, target}) begin
                level_next = target;
            end else begin
                level_next = level_up[7:0];
            end
        end else if (level > target) begin
            if (({1'b0, level} < SLEW_9) || (level_dn < {1'b0, target})) begin
                level_next = target;
            end else begin
                level_next = level_dn[7:0];
            end
        end else begin
            level_next = level;
        end
    end

    // Phase input pipeline and target lookup.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q    <= 4'd0;
            cnt_prev <= 4'd0;
            target   <= 8'd0;
        end else begin
            cnt_q    <= heart_cnt_in;
            cnt_prev <= cnt_q;
            target   <= phase_target(cnt_q);
        end
    end

    // Prescaler and free-running PWM counter; both parked at 0 while disabled.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            presc   <= 8'd0;
            pwm_cnt <= 8'd0;
        end else if (!en_in) begin
            presc   <= 8'd0;
            pwm_cnt <= 8'd0;
        end else if (tick) begin
            presc   <= 8'd0;
            pwm_cnt <= pwm_cnt + 8'd1;
        end else begin
            presc   <= presc + 8'd1;
            pwm_cnt <= pwm_cnt;
        end
    end

    // Brightness level moves only at the end of a PWM period.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            level <= 8'd0;
        end else if (!en_in) begin
            level <= 8'd0;
        end else if (period_end) begin
            level <= level_next;
        end else begin
            level <= level;
        end
    end

    // Registered LED drive, beat pulse and sticky out-of-range flag.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            led_n_out <= 1'b1;
            beat_out  <= 1'b0;
            err_out   <= 1'b0;
        end else begin
            led_n_out <= ~(en_in && (level > pwm_cnt));
            beat_out  <= en_in && (cnt_q == 4'd0) && (cnt_prev == 4'd7);
            err_out   <= err_out || (cnt_q > 4'd7);
        end
    end

    assign level_out = level;

endmodule

// File: tb/tb_heart_led_pwm.sv
// Scoreboard bench for heart_led_pwm: two instances (PWM_DIV=1/SLEW=16 and
// PWM_DIV=2/SLEW=100) share stimulus; expectations are tagged with the cycle they apply to.
module tb_heart_led_pwm;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] heart;
    logic       led_a, beat_a, err_a, led_b, beat_b, err_b;
    logic [7:0] level_a, level_b;

    heart_led_pwm #(.PWM_DIV(1), .SLEW(16)) dut_a (
        .clk_in(clk), .rst_in(rst), .en_in(en), .heart_cnt_in(heart),
        .led_n_out(led_a), .beat_out(beat_a), .level_out(level_a), .err_out(err_a)
    );

    heart_led_pwm #(.PWM_DIV(2), .SLEW(100)) dut_b (
        .clk_in(clk), .rst_in(rst), .en_in(en), .heart_cnt_in(heart),
        .led_n_out(led_b), .beat_out(beat_b), .level_out(level_b), .err_out(err_b)
    );

    always #20 clk = ~clk;

    localparam int LED_A = 0, BEAT_A = 1, LEVEL_A = 2, ERR_A = 3;
    localparam int LED_B = 4, BEAT_B = 5, LEVEL_B = 6, ERR_B = 7;

    typedef struct {
        int tag;
        int sel;
        int val;
    } chk_t;

    chk_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   mon_act;
    int   c0, c1, c2, c3, c4, c5, c6, c7, c8;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int actual(input int sel);
        case (sel)
            LED_A:   return int'(led_a);
            BEAT_A:  return int'(beat_a);
            LEVEL_A: return int'(level_a);
            ERR_A:   return int'(err_a);
            LED_B:   return int'(led_b);
            BEAT_B:  return int'(beat_b);
            LEVEL_B: return int'(level_b);
            ERR_B:   return int'(err_b);
            default: return -1;
        endcase
    endfunction

    function automatic string sel_name(input int sel);
        case (sel)
            LED_A:   return "led_a";
            BEAT_A:  return "beat_a";
            LEVEL_A: return "level_a";
            ERR_A:   return "err_a";
            LED_B:   return "led_b";
            BEAT_B:  return "beat_b";
            LEVEL_B: return "level_b";
            ERR_B:   return "err_b";
            default: return "unknown";
        endcase
    endfunction

    task automatic expect_at(input int tag, input int sel, input int val);
        chk_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic goto(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: compares every expectation due in the current cycle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].tag <= cyc) begin
                    n_vec++;
                    mon_act = actual(sb[i].sel);
                    if (sb[i].tag != cyc || mon_act != sb[i].val) begin
                        n_bad++;
                        $display("FAIL %s @cycle %0d (due %0d): got %0d, expected %0d",
                                 sel_name(sb[i].sel), cyc, sb[i].tag, mon_act, sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        heart = 4'd0;

        // Reset state, then release with phase 0 (target 255).
        goto(2);
        c0 = cyc;
        expect_at(c0, LED_A, 1);   expect_at(c0, BEAT_A, 0);
        expect_at(c0, LEVEL_A, 0); expect_at(c0, ERR_A, 0);
        expect_at(c0, LED_B, 1);   expect_at(c0, LEVEL_B, 0);
        rst = 1'b0;
        en  = 1'b1;

        for (int k = 1; k <= 16; k++) begin
            expect_at(c0 + 256 * k - 1, LEVEL_A, 16 * (k - 1));
            expect_at(c0 + 256 * k, LEVEL_A, (16 * k > 255) ? 255 : 16 * k);
        end
        expect_at(c0 + 257, LED_A, 0);
        expect_at(c0 + 272, LED_A, 0);
        expect_at(c0 + 273, LED_A, 1);
        expect_at(c0 + 4351, LED_A, 0);
        expect_at(c0 + 4352, LED_A, 1);
        expect_at(c0 + 4353, LED_A, 0);
        expect_at(c0 + 511, LEVEL_B, 0);
        expect_at(c0 + 512, LEVEL_B, 100);
        expect_at(c0 + 1024, LEVEL_B, 200);
        expect_at(c0 + 1536, LEVEL_B, 255);

        // Ramp down toward 32 from 255; mid-period target change waits for period end.
        c1 = c0 + 4360;
        c2 = c0 + 6200;
        goto(c1);
        heart = 4'd3;
        expect_at(c0 + 4607, LEVEL_A, 255);
        expect_at(c0 + 4608, LEVEL_A, 239);
        expect_at(c0 + 4608, LEVEL_B, 155);
        expect_at(c0 + 5120, LEVEL_B, 55);
        expect_at(c0 + 5632, LEVEL_B, 32);
        expect_at(c0 + 6144, LEVEL_B, 32);
        expect_at(c2 - 1, LEVEL_A, 143);
        expect_at(c2 - 1, LEVEL_B, 32);

        // Asynchronous reset with nonzero levels.
        goto(c2);
        rst   = 1'b1;
        heart = 4'd0;
        expect_at(c2, LEVEL_A, 0); expect_at(c2, LEVEL_B, 0);
        expect_at(c2, LED_A, 1);   expect_at(c2, ERR_B, 0);

        // Ramp to 128 then reset mid-ramp.
        c3 = c2 + 5;
        goto(c3);
        rst = 1'b0;
        expect_at(c3 + 2048, LEVEL_A, 128);
        expect_at(c3 + 2099, LEVEL_A, 128);
        expect_at(c3 + 2099, LEVEL_B, 255);
        expect_at(c3 + 2100, LEVEL_A, 0);
        expect_at(c3 + 2100, LED_A, 1);
        expect_at(c3 + 2100, BEAT_A, 0);
        expect_at(c3 + 2100, LEVEL_B, 0);
        goto(c3 + 2100);
        rst = 1'b1;

        // Release; first period end lands a full period later. Target 192.
        c4 = c3 + 2103;
        goto(c4);
        rst   = 1'b0;
        heart = 4'd2;
        expect_at(c4 + 255, LEVEL_A, 0);
        expect_at(c4 + 256, LEVEL_A, 16);
        expect_at(c4 + 3071, LEVEL_A, 176);
        expect_at(c4 + 3072, LEVEL_A, 192);
        expect_at(c4 + 511, LEVEL_B, 0);
        expect_at(c4 + 512, LEVEL_B, 100);
        expect_at(c4 + 1024, LEVEL_B, 192);

        // Drop enable at level 192; beat must be suppressed while disabled.
        c5 = c4 + 3100;
        expect_at(c5, LEVEL_A, 192);
        expect_at(c5, LED_A, 0);
        expect_at(c5 + 1, LEVEL_A, 0);
        expect_at(c5 + 1, LED_A, 1);
        expect_at(c5 + 1, LEVEL_B, 0);
        expect_at(c5 + 1, LED_B, 1);
        for (int t = 4; t <= 6; t++) expect_at(c5 + t, BEAT_A, 0);
        goto(c5);
        en = 1'b0;
        goto(c5 + 2);
        heart = 4'd7;
        goto(c5 + 3);
        heart = 4'd0;
        goto(c5 + 4);
        heart = 4'd2;

        // Re-enable with phase 2; ramp restarts from 0, then phase 9 takes target to 0.
        c6 = c5 + 10;
        goto(c6);
        en = 1'b1;
        expect_at(c6 + 255, LEVEL_A, 0);
        expect_at(c6 + 256, LEVEL_A, 16);
        expect_at(c6 + 512, LEVEL_A, 32);
        expect_at(c6 + 768, LEVEL_A, 16);
        expect_at(c6 + 1024, LEVEL_A, 0);
        expect_at(c6 + 511, LEVEL_B, 0);
        expect_at(c6 + 512, LEVEL_B, 100);
        expect_at(c6 + 1024, LEVEL_B, 0);
        expect_at(c6 + 1024, ERR_A, 1);

        // Beat: 0..7 three times, then 7->6->0 and 0->0 which must not pulse.
        c7 = c6 + 600;
        for (int t = 1; t <= 30; t++) begin
            expect_at(c7 + t, BEAT_A, (t == 10 || t == 18) ? 1 : 0);
        end
        expect_at(c7 + 10, BEAT_B, 1);
        expect_at(c7 + 5, ERR_A, 0);
        for (int i = 0; i < 24; i++) begin
            goto(c7 + i);
            heart = 4'(i % 8);
        end
        goto(c7 + 24);
        heart = 4'd6;
        goto(c7 + 25);
        heart = 4'd0;

        // Single-clock out-of-range phase, then hold it.
        c8 = c7 + 40;
        expect_at(c8 + 1, ERR_A, 0);
        expect_at(c8 + 2, ERR_A, 1);
        expect_at(c8 + 2, ERR_B, 1);
        expect_at(c8 + 9, ERR_A, 1);
        goto(c8);
        heart = 4'd9;
        goto(c8 + 1);
        heart = 4'd0;
        goto(c8 + 10);
        heart = 4'd9;

        goto(c6 + 1030);
        for (int w = 0; w < 50 && sb.size() > 0; w++) @(negedge clk);
        if (sb.size() > 0) begin
            n_bad += sb.size();
            $display("FAIL drain: %0d expectations never checked, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
